// File: rtl/ex_muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_seq_if
//  Bundle between the EX stage and the multi-cycle multiply/divide sequencer.
//  master : pipeline side (drives requests, receives status and HI/LO)
//  slave  : sequencer side
//  Signals:
//   start        request; only sampled while the sequencer is idle
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   opA / opB    multiplicand/dividend, multiplier/divisor
//   flush        kill the in-flight operation
//   busy         operation in flight (prep / iterate / sign fix)
//   stall_req    combinational hold request for IF/ID/EX
//   done         one-cycle completion pulse
//   div_by_zero  qualifies done: divide with a zero divisor
//   hi / lo      architectural HI/LO registers
// ---------------------------------------------------------------------------
interface ex_muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             flush;
   logic             busy;
   logic             stall_req;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, opA, opB, flush,
      input  busy, stall_req, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, opA, opB, flush,
      output busy, stall_req, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/ex_muldiv_seq.sv
// ---------------------------------------------------------------------------
// ex_muldiv_seq
//  Multi-cycle multiply/divide sequencer sitting beside EX. Executes
//  MULT/MULTU/DIV/DIVU one bit per cycle (shift-add multiply, restoring
//  divide) and owns HI/LO, which change only when an operation completes.
//  Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   ex_muldiv_seq_if.slave (request, flush, status, HI/LO)
//  Timing: accept edge -> PREP -> WIDTH x CALC -> FIX -> DONE, so done is
//  high WIDTH+2 edges after acceptance. A divide by zero skips CALC and
//  reaches DONE two edges after acceptance.
// ---------------------------------------------------------------------------
module ex_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst,
   ex_muldiv_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PREP = 3'd1;
   localparam logic [2:0] S_CALC = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]         state_reg, state_next;
   logic [CW-1:0]      count_reg;
   // Upper half: partial product / partial remainder.
   // Lower half: multiplier shifting out / dividend shifting out, quotient shifting in.
   logic [2*WIDTH-1:0] acc_reg, acc_next;
   logic [WIDTH-1:0]   dvsr_reg;      // multiplicand or divisor magnitude
   logic [1:0]         op_reg;
   logic               neg_q_reg;     // product / quotient must be negated
   logic               neg_r_reg;     // remainder takes the dividend's sign
   logic               dbz_flag_reg;  // current op is a divide by zero
   logic [WIDTH-1:0]   hi_reg, lo_reg;
   logic               dbz_reg;

   logic               accept;
   logic               is_div, is_signed;
   logic               a_neg, b_neg, div0;
   logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   hi_res, lo_res;

   assign accept    = bus.start & (state_reg == S_IDLE) & ~bus.flush;
   assign is_div    = op_reg[1];
   assign is_signed = op_reg[0];

   // Sign inspection happens in PREP on the latched raw operands.
   assign a_neg = is_signed & acc_reg[WIDTH-1];
   assign b_neg = is_signed & dvsr_reg[WIDTH-1];
   assign div0  = is_div & (dvsr_reg == {WIDTH{1'b0}});

   // Multiply step: add multiplicand when the outgoing multiplier bit is set,
   // keep the carry as the new top bit and shift the whole pair right.
   assign add_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, dvsr_reg} : {(WIDTH+1){1'b0}});

   // Divide step: bring the next dividend bit into the partial remainder and
   // trial-subtract. The partial remainder is always below the divisor, so the
   // shifted value fits in WIDTH+1 bits and bit WIDTH of the difference is the
   // borrow.
   assign rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, dvsr_reg};

   always_comb begin
      acc_next = acc_reg;
      if (is_div) begin
         if (!rem_diff[WIDTH])
            acc_next = {rem_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
         else
            acc_next = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      end else begin
         acc_next = {add_sum, acc_reg[WIDTH-1:1]};
      end
   end

   // Sign correction and result selection, written into HI/LO on the FIX edge.
   assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;

   always_comb begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
      if (dbz_flag_reg) begin
         // Lower half still holds the untouched dividend.
         hi_res = acc_reg[WIDTH-1:0];
         lo_res = {WIDTH{1'b1}};
      end else if (is_div) begin
         lo_res = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
         hi_res = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      state_next = state_reg;
      if (bus.flush) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE: if (bus.start) state_next = S_PREP;
            // A zero divisor skips the iterations but still passes through FIX,
            // keeping the single HI/LO write point.
            S_PREP: state_next = div0 ? S_FIX : S_CALC;
            S_CALC: if (count_reg == CW'(WIDTH-1)) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         count_reg    <= '0;
         acc_reg      <= '0;
         dvsr_reg     <= '0;
         op_reg       <= '0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         dbz_flag_reg <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         dbz_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  acc_reg  <= {{WIDTH{1'b0}}, bus.opA};
                  dvsr_reg <= bus.opB;
                  op_reg   <= bus.op;
               end
            end
            S_PREP: begin
               neg_q_reg    <= a_neg ^ b_neg;
               neg_r_reg    <= a_neg;
               dbz_flag_reg <= div0;
               count_reg    <= '0;
               if (!div0) begin
                  acc_reg[WIDTH-1:0] <= a_neg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
                  dvsr_reg           <= b_neg ? -dvsr_reg : dvsr_reg;
               end
            end
            S_CALC: begin
               acc_reg   <= acc_next;
               count_reg <= count_reg + CW'(1);
            end
            S_FIX: begin
               // A flush in FIX kills the op before HI/LO are touched.
               if (!bus.flush) begin
                  hi_reg  <= hi_res;
                  lo_reg  <= lo_res;
                  dbz_reg <= dbz_flag_reg;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (state_reg == S_PREP) | (state_reg == S_CALC) | (state_reg == S_FIX);
   assign bus.stall_req   = accept | bus.busy;
   assign bus.done        = (state_reg == S_DONE);
   assign bus.div_by_zero = dbz_reg;
   assign bus.hi          = hi_reg;
   assign bus.lo          = lo_reg;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_seq
//  Directed bench for ex_muldiv_seq. A timeline model (edges since accept,
//  plain 64-bit arithmetic for the results) predicts busy/done/stall/HI/LO,
//  checked on every falling edge; directed transactions additionally check
//  hand-computed literal results and latencies.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_seq;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ex_muldiv_seq_if #(.WIDTH(W)) bus ();

   ex_muldiv_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_active = 1'b0;
   int          m_edges  = 0;
   int          m_lat    = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   bit          m_dbz = 1'b0;
   logic [31:0] r_hi, r_lo;
   bit          r_dbz;
   longint      m_sa, m_sb, m_q, m_r;
   logic [63:0] m_p;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active = 1'b0;
         m_edges  = 0;
         m_hi     = '0;
         m_lo     = '0;
         m_dbz    = 1'b0;
      end else if (m_active) begin
         if (bus.flush) begin
            m_active = 1'b0;
         end else begin
            m_edges++;
            if (m_edges == m_lat) begin
               m_hi  = r_hi;
               m_lo  = r_lo;
               m_dbz = r_dbz;
            end else if (m_edges > m_lat) begin
               m_active = 1'b0;
            end
         end
      end else if (bus.start && !bus.flush) begin
         m_active = 1'b1;
         m_edges  = 0;
         if (bus.op[0]) begin
            m_sa = longint'($signed(bus.opA));
            m_sb = longint'($signed(bus.opB));
         end else begin
            m_sa = longint'({32'd0, bus.opA});
            m_sb = longint'({32'd0, bus.opB});
         end
         if (bus.op[1]) begin
            if (bus.opB == 32'd0) begin
               r_hi = bus.opA; r_lo = '1; r_dbz = 1'b1; m_lat = 2;
            end else begin
               m_q = m_sa / m_sb;
               m_r = m_sa % m_sb;
               r_lo = m_q[31:0]; r_hi = m_r[31:0]; r_dbz = 1'b0; m_lat = W + 2;
            end
         end else begin
            m_p  = 64'(m_sa * m_sb);
            r_hi = m_p[63:32]; r_lo = m_p[31:0]; r_dbz = 1'b0; m_lat = W + 2;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         bit e_busy, e_done, e_stall;
         e_busy  = m_active && (m_edges < m_lat);
         e_done  = m_active && (m_edges == m_lat);
         e_stall = (bus.start && !m_active && !bus.flush) || e_busy;
         check("cyc_busy",  64'(bus.busy),      64'(e_busy));
         check("cyc_done",  64'(bus.done),      64'(e_done));
         check("cyc_stall", 64'(bus.stall_req), 64'(e_stall));
         check("cyc_hi",    64'(bus.hi),        64'(m_hi));
         check("cyc_lo",    64'(bus.lo),        64'(m_lo));
         if (e_done) check("cyc_dbz", 64'(bus.div_by_zero), 64'(m_dbz));
      end
   end

   // ---------------- directed transaction ----------------
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input bit edbz, input int elat);
      int n;
      bit seen;
      n = -1;
      seen = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = op; bus.opA = a; bus.opB = b;
      @(negedge clk);
      check({tag, "_stall_start"}, 64'(bus.stall_req), 64'd1);
      @(posedge clk); #1;   // accepting edge
      bus.start = 1'b0;
      bus.op    = 2'($urandom_range(0, 3));
      bus.opA   = $urandom;
      bus.opB   = $urandom;
      for (int k = 0; k <= 100; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            n = k;
            break;
         end
         @(posedge clk);
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_latency"},   64'(n),    64'(elat));
      check({tag, "_hi"},  64'(bus.hi), 64'(ehi));
      check({tag, "_lo"},  64'(bus.lo), 64'(elo));
      check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
      $display("op %s: op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b latency=%0d",
               tag, op, a, b, bus.hi, bus.lo, bus.div_by_zero, n);
   endtask

   initial begin
      int ndone, first_k, second_k;
      bus.start = 1'b0; bus.op = 2'd0; bus.opA = '0; bus.opB = '0; bus.flush = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  64'(bus.busy), 64'd0);
      check("rst_done",  64'(bus.done), 64'd0);
      check("rst_dbz",   64'(bus.div_by_zero), 64'd0);
      check("rst_hi",    64'(bus.hi), 64'd0);
      check("rst_lo",    64'(bus.lo), 64'd0);
      check("rst_stall", 64'(bus.stall_req), 64'd0);
      rst = 1'b1;
      chk_en = 1'b1;

      // Arithmetic vectors
      run_op("multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
      run_op("mult_neg",  2'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
      run_op("div_neg",   2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
      run_op("divu_100_7",2'd2, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34);
      run_op("div_wrap",  2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
      run_op("div_negb",  2'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34);
      run_op("mult_min",  2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34);
      run_op("divu_by0",  2'd2, 32'h00000064, 32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 2);
      run_op("div_by0",   2'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2);

      // Flush at CALC iteration 10: back to idle, HI/LO untouched
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'd0; bus.opA = 32'd5; bus.opB = 32'd6;
      @(posedge clk); #1;   // accepting edge
      bus.start = 1'b0;
      repeat (11) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check("flush_busy", 64'(bus.busy), 64'd0);
      check("flush_hi",   64'(bus.hi), 64'hFFFFFFF9);
      check("flush_lo",   64'(bus.lo), 64'hFFFFFFFF);
      $display("op flush: multu 5*6 killed at iteration 10, hi=%h lo=%h", bus.hi, bus.lo);
      run_op("multu_5_6", 2'd0, 32'd5, 32'd6, 32'h00000000, 32'h0000001E, 1'b0, 34);

      // start together with flush while idle: nothing starts
      @(posedge clk); #1;
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd0; bus.opA = 32'd9; bus.opB = 32'd9;
      @(negedge clk);
      check("sflush_stall", 64'(bus.stall_req), 64'd0);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      check("sflush_busy", 64'(bus.busy), 64'd0);
      $display("op start+flush idle: busy=%0b", bus.busy);

      // start held high continuously: one done per op, next accept after DONE
      ndone = 0; first_k = -1; second_k = -1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'd0; bus.opA = 32'd3; bus.opB = 32'd4;
      @(posedge clk); #1;   // accepting edge
      for (int k = 0; k <= 90; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ndone++;
            if (ndone == 1) first_k = k;
            else second_k = k;
         end
         if (ndone >= 2) break;
         @(posedge clk);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("hold_ndone",  64'(ndone),    64'd2);
      check("hold_first",  64'(first_k),  64'd34);
      check("hold_second", 64'(second_k), 64'd70);
      check("hold_lo",     64'(bus.lo),   64'h0000000C);
      $display("op held-start: dones=%0d at %0d and %0d", ndone, first_k, second_k);
      repeat (3) @(posedge clk);

      // Asynchronous reset in the middle of CALC
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'd3; bus.opA = 32'h12345678; bus.opB = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_done", 64'(bus.done), 64'd0);
      check("arst_hi",   64'(bus.hi),   64'd0);
      check("arst_lo",   64'(bus.lo),   64'd0);
      $display("op async reset mid-calc: busy=%0b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
      @(posedge clk); #1;
      rst = 1'b1;
      run_op("post_rst", 2'd2, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 34);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
